// File: rtl/sys_arbiter.sv
// Two-master arbiter for the shared system-memory port (M0 = icache, M1 = dcache).
// Whole-transaction round-robin grants with beat counting and a no-response watchdog.
module sys_arbiter #(
  parameter int BEATS   = 16,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        M0Strobe,
  input  logic        M0RW,
  input  logic [31:0] M0Address,
  input  logic [31:0] M0Data_out,
  output logic [31:0] M0Data_in,
  output logic        M0Ack,
  output logic        M0Ready,

  input  logic        M1Strobe,
  input  logic        M1RW,
  input  logic [31:0] M1Address,
  input  logic [31:0] M1Data_out,
  output logic [31:0] M1Data_in,
  output logic        M1Ack,
  output logic        M1Ready,

  output logic        SysStrobe,
  output logic        SysRW,
  output logic [31:0] SysAddress,
  output logic [31:0] SysData_in,
  input  logic [31:0] SysData_out,
  input  logic        SysAck,
  input  logic        SysReady,

  output logic [1:0]  Grant,
  output logic [4:0]  BeatCount,
  output logic        Overrun,
  output logic        Timeout
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;

  localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT);
  localparam logic [4:0]    BEATS_V  = 5'(BEATS);

  state_t        state;
  logic          last_m1;
  logic [CW-1:0] wdog;

  logic busy0, busy1, busy;
  logic own_strobe;
  logic wdog_fire;
  logic leave;

  always_comb begin
    busy0      = (state == BUSY0);
    busy1      = (state == BUSY1);
    busy       = busy0 | busy1;
    own_strobe = (busy0 & M0Strobe) | (busy1 & M1Strobe);
    // Any response in the firing cycle counts as activity, so SysReady wins over the watchdog.
    wdog_fire  = busy & (wdog == WDOG_MAX) & ~SysAck & ~SysReady;
    leave      = busy & (SysReady | ~own_strobe | wdog_fire);
  end

  always_comb begin
    SysStrobe  = own_strobe;
    SysRW      = 1'b0;
    SysAddress = '0;
    SysData_in = '0;
    if (busy0) begin
      SysRW      = M0RW;
      SysAddress = M0Address;
      SysData_in = M0Data_out;
    end else if (busy1) begin
      SysRW      = M1RW;
      SysAddress = M1Address;
      SysData_in = M1Data_out;
    end
    M0Data_in = busy ? SysData_out : '0;
    M1Data_in = busy ? SysData_out : '0;
    M0Ack     = busy0 & SysAck;
    M1Ack     = busy1 & SysAck;
    // The watchdog pulse on Ready lets a stalled cache drop its request.
    M0Ready   = busy0 & (SysReady | wdog_fire);
    M1Ready   = busy1 & (SysReady | wdog_fire);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Grant     <= 2'b00;
      BeatCount <= '0;
      Overrun   <= 1'b0;
      Timeout   <= 1'b0;
      last_m1   <= 1'b1;
      wdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (M0Strobe || M1Strobe) begin
            BeatCount <= '0;
            wdog      <= '0;
            if (M0Strobe && (!M1Strobe || last_m1)) begin
              state <= BUSY0;
              Grant <= 2'b01;
            end else begin
              state <= BUSY1;
              Grant <= 2'b10;
            end
            // Only a genuine tie moves the round-robin pointer.
            if (M0Strobe && M1Strobe) last_m1 <= !last_m1;
          end
        end
        BUSY0, BUSY1: begin
          if (SysAck) begin
            if (BeatCount != 5'd31) BeatCount <= BeatCount + 5'd1;
            if (BeatCount == BEATS_V) Overrun <= 1'b1;
          end
          wdog <= (SysAck || SysReady) ? '0 : wdog + 1'b1;
          if (leave) begin
            state <= RELEASE;
            Grant <= 2'b00;
            if (wdog_fire) Timeout <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_arbiter.sv
// Directed bench for sys_arbiter: stimulus pushes expected grant/ready events,
// a negedge monitor pops and compares them as the arbiter presents them.
`timescale 1ns/1ps
module tb_sys_arbiter;

  logic        clock;
  logic        reset;
  logic        M0Strobe, M0RW, M0Ack, M0Ready;
  logic [31:0] M0Address, M0Data_out, M0Data_in;
  logic        M1Strobe, M1RW, M1Ack, M1Ready;
  logic [31:0] M1Address, M1Data_out, M1Data_in;
  logic        SysStrobe, SysRW, SysAck, SysReady;
  logic [31:0] SysAddress, SysData_in, SysData_out;
  logic [1:0]  Grant;
  logic [4:0]  BeatCount;
  logic        Overrun, Timeout;

  sys_arbiter #(.BEATS(16), .TIMEOUT(255), .CW(8)) dut (
    .clock(clock), .reset(reset),
    .M0Strobe(M0Strobe), .M0RW(M0RW), .M0Address(M0Address), .M0Data_out(M0Data_out),
    .M0Data_in(M0Data_in), .M0Ack(M0Ack), .M0Ready(M0Ready),
    .M1Strobe(M1Strobe), .M1RW(M1RW), .M1Address(M1Address), .M1Data_out(M1Data_out),
    .M1Data_in(M1Data_in), .M1Ack(M1Ack), .M1Ready(M1Ready),
    .SysStrobe(SysStrobe), .SysRW(SysRW), .SysAddress(SysAddress), .SysData_in(SysData_in),
    .SysData_out(SysData_out), .SysAck(SysAck), .SysReady(SysReady),
    .Grant(Grant), .BeatCount(BeatCount), .Overrun(Overrun), .Timeout(Timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] addr;
  } gexp_t;

  gexp_t      exp_grant_q[$];
  logic [6:0] exp_ready_q[$];   // {M1Ready, M0Ready, BeatCount}

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    chk_cnt++;
    $display("FAIL %s: unexpected event, value %0h, nothing expected", name, act);
  endtask

  // Monitor: grant rising edges and Ready pulses are compared against the queues.
  logic [1:0] grant_prev;
  gexp_t      mon_g;
  logic [6:0] mon_r;
  always @(negedge clock) begin
    if (!reset) begin
      grant_prev = 2'b00;
    end else begin
      if (grant_prev == 2'b00 && Grant != 2'b00) begin
        if (exp_grant_q.size() == 0) unexpected("grant_event", {30'd0, Grant});
        else begin
          mon_g = exp_grant_q.pop_front();
          check("grant_order", {Grant, SysAddress}, {mon_g.grant, mon_g.addr});
        end
      end
      grant_prev = Grant;
      if (M0Ready || M1Ready) begin
        if (exp_ready_q.size() == 0) unexpected("ready_event", {25'd0, M1Ready, M0Ready, BeatCount});
        else begin
          mon_r = exp_ready_q.pop_front();
          check("ready_event", {M1Ready, M0Ready, BeatCount}, mon_r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input int m, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      M0Strobe = 1'b1; M0RW = rw; M0Address = addr; M0Data_out = wd;
    end else begin
      M1Strobe = 1'b1; M1RW = rw; M1Address = addr; M1Data_out = wd;
    end
  endtask

  task automatic wait_grant(input int m);
    int n;
    n = 0;
    while (!Grant[m] && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("grant_wait", {30'd0, Grant}, (m == 0) ? 160'd1 : 160'd2);
  endtask

  task automatic beat(input int m, input logic [31:0] d);
    SysAck      = 1'b1;
    SysData_out = d;
    @(negedge clock);
    check("ack_route", {M1Ack, M0Ack}, (m == 0) ? 160'd1 : 160'd2);
    check("rd_data", (m == 0) ? M0Data_in : M1Data_in, d);
    step();
    SysAck = 1'b0;
  endtask

  // Full transaction for master m: wait for grant, n acks, then SysReady; master drops strobe.
  task automatic serve(input int m, input logic [31:0] addr, input int n);
    logic [31:0] d;
    wait_grant(m);
    for (int i = 0; i < n; i++) begin
      d = addr ^ i;
      beat(m, d);
    end
    check("beat_count", BeatCount, n);
    SysReady = 1'b1;
    @(negedge clock);
    step();
    SysReady = 1'b0;
    if (m == 0) M0Strobe = 1'b0; else M1Strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    M0Strobe = 0; M0RW = 0; M0Address = 0; M0Data_out = 0;
    M1Strobe = 0; M1RW = 0; M1Address = 0; M1Data_out = 0;
    SysData_out = 32'h5555_AAAA; SysAck = 0; SysReady = 0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {SysStrobe, SysRW, SysAddress, SysData_in, M0Data_in, M0Ack, M0Ready,
                          M1Data_in, M1Ack, M1Ready, Grant, BeatCount, Overrun, Timeout}, 160'd0);
    reset = 1'b1;

    // M0 line fill: grant one cycle after strobe, 16 beats, Ready, release
    request(0, 1'b1, 32'h1000_0040, 32'h0);
    exp_grant_q.push_back('{2'b01, 32'h1000_0040});
    exp_ready_q.push_back({2'b01, 5'd16});
    @(negedge clock);
    check("lat_idle", SysStrobe, 160'd0);
    step();
    @(negedge clock);
    check("lat_grant", {Grant, SysStrobe, SysRW}, {2'b01, 1'b1, 1'b1});
    step();
    serve(0, 32'h1000_0040, 16);
    @(negedge clock);
    check("release_idle", {Grant, SysStrobe, M0Ready}, 160'd0);
    check("no_overrun_16", Overrun, 160'd0);
    step();

    // Both masters request continuously: ties alternate M0, M1, M0, M1
    request(0, 1'b0, 32'h2000_0000, 32'hC0C0_0000);
    request(1, 1'b0, 32'h3000_0000, 32'hC1C1_0000);
    for (int k = 0; k < 4; k++) begin
      exp_grant_q.push_back((k % 2 == 0) ? '{2'b01, 32'h2000_0000} : '{2'b10, 32'h3000_0000});
      exp_ready_q.push_back((k % 2 == 0) ? {2'b01, 5'd0} : {2'b10, 5'd0});
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (Grant == 2'b00 && n < 10) begin
        step();
        n++;
      end
      SysAck = 1'b1; SysReady = 1'b1;
      @(negedge clock);
      step();
      SysAck = 1'b0; SysReady = 1'b0;
      check("ack_ready_beat", BeatCount, 160'd1);
    end
    M0Strobe = 1'b0; M1Strobe = 1'b0;
    step();

    // M1 write in progress, M0 waits until after SysReady and the release cycle
    request(1, 1'b0, 32'h4000_0010, 32'hDA7A_0001);
    exp_grant_q.push_back('{2'b10, 32'h4000_0010});
    exp_ready_q.push_back({2'b10, 5'd1});
    wait_grant(1);
    @(negedge clock);
    check("mux_m1", {SysRW, SysData_in, SysAddress}, {1'b0, 32'hDA7A_0001, 32'h4000_0010});
    step();
    request(0, 1'b1, 32'h5000_0080, 32'h0);
    exp_grant_q.push_back('{2'b01, 32'h5000_0080});
    beat(1, 32'h0000_0077);
    @(negedge clock);
    check("no_preempt", Grant, 160'd2);
    step();
    SysReady = 1'b1;
    @(negedge clock);
    step();
    SysReady = 1'b0; M1Strobe = 1'b0;
    @(negedge clock);
    check("gap_cycle1", {SysStrobe, Grant}, 160'd0);
    step();
    @(negedge clock);
    check("gap_cycle2", {SysStrobe, Grant}, 160'd0);
    step();
    @(negedge clock);
    check("m0_after_gap", {SysStrobe, Grant, SysAddress}, {1'b1, 2'b01, 32'h5000_0080});

    // Memory stays silent: watchdog fires in the cycle its count reaches 255
    exp_ready_q.push_back({2'b01, 5'd0});
    n = 0;
    while (!M0Ready && n < 300) begin
      step();
      @(negedge clock);
      n++;
    end
    check("wdog_latency", n, 160'd255);
    step();
    M0Strobe = 1'b0;
    @(negedge clock);
    check("after_timeout", {Grant, M0Ready, Timeout, Overrun}, {2'b00, 1'b0, 1'b1, 1'b0});
    step();
    request(1, 1'b1, 32'h6000_0000, 32'h0);
    exp_grant_q.push_back('{2'b10, 32'h6000_0000});
    exp_ready_q.push_back({2'b10, 5'd4});
    serve(1, 32'h6000_0000, 4);
    check("timeout_sticky", Timeout, 160'd1);
    step();

    // 17 acks in one M1 grant
    request(1, 1'b1, 32'h7000_0000, 32'h0);
    exp_grant_q.push_back('{2'b10, 32'h7000_0000});
    exp_ready_q.push_back({2'b10, 5'd17});
    serve(1, 32'h7000_0000, 17);
    check("overrun_17", {Overrun, BeatCount}, {1'b1, 5'd17});
    step();

    // Reset asserted during M1's 8th beat, then a fresh full fill
    request(1, 1'b1, 32'h8000_0000, 32'h0);
    exp_grant_q.push_back('{2'b10, 32'h8000_0000});
    wait_grant(1);
    for (int i = 0; i < 7; i++) beat(1, 32'h8000_0000 + i);
    check("pre_reset_beats", BeatCount, 160'd7);
    SysAck = 1'b1; SysData_out = 32'hDEAD_BEEF;
    #2;
    reset = 1'b0;
    #1;
    check("reset_async", {SysStrobe, SysRW, SysAddress, SysData_in, M0Data_in, M0Ack, M0Ready,
                          M1Data_in, M1Ack, M1Ready, Grant, BeatCount, Overrun, Timeout}, 160'd0);
    SysAck = 1'b0; M1Strobe = 1'b0;
    step();
    reset = 1'b1;
    step();
    request(1, 1'b1, 32'h9000_0000, 32'h0);
    exp_grant_q.push_back('{2'b10, 32'h9000_0000});
    exp_ready_q.push_back({2'b10, 5'd16});
    serve(1, 32'h9000_0000, 16);
    check("flags_after_reset", {Overrun, Timeout}, 160'd0);

    repeat (3) step();
    check("grant_q_drained", exp_grant_q.size(), 160'd0);
    check("ready_q_drained", exp_ready_q.size(), 160'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
